// File: rtl/io_bus_scheduler.sv
// Round-robin scheduler for the shared emulData bus and panel strobes.
// Ports: Clock_1us/Rst_n; in12/kb/ms request+payload in, done out;
//   emulData bus, peripheral strobes, kb_row, busy. Macro IO_BUS_TIMEOUT_EN
//   enables the ms6205_ready wait timeout (ms_timeout tied 0 otherwise).
module io_bus_scheduler #(
   parameter int SETTLE_US     = 2,
   parameter int STROBE_US     = 4,
   parameter int READY_TIMEOUT = 255
) (
   input  logic       Clock_1us,
   input  logic       Rst_n,
   input  logic       in12_req,
   input  logic [7:0] in12_cathode,
   input  logic [3:0] in12_anode,
   output logic       in12_done,
   input  logic       kb_req,
   input  logic [7:0] kb_col,
   input  logic [6:0] keyboard_data_in,
   output logic [6:0] kb_row,
   output logic       kb_done,
   input  logic       ms_req,
   input  logic [7:0] ms_addr,
   input  logic [7:0] ms_data,
   input  logic       ms6205_ready,
   output logic       ms_done,
   output logic       ms_timeout,
   output logic [7:0] emulData,
   output logic       in12_write_cathode,
   output logic       in12_write_anode,
   output logic       keyboard_write,
   output logic       keyboard_read,
   output logic       ms6205_write_addr_n,
   output logic       ms6205_write_data_n,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_RDY, S_SETUP, S_STROBE, S_HOLD
   } state_t;

   localparam logic [7:0] SETUP_LAST  = 8'(SETTLE_US - 1);
   localparam logic [7:0] STROBE_LAST = 8'(STROBE_US - 1);

   state_t     state_q, state_d;
   logic       phase_q, phase_d;
   // one-hot requester select: {ms, kb, in12}
   logic [2:0] sel_q, sel_d;
   logic [2:0] last_q, last_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] pay0_q, pay0_d;
   logic [7:0] pay1_q, pay1_d;
   logic [2:0] reqs, win;
   logic       abort;

   logic [7:0] bus_d;
   logic       drive, stb;
   logic       wc_d, wa_d, kw_d, kr_d, ma_d, md_d;
   logic       last_ph;
   logic [6:0] row_d;

`ifdef IO_BUS_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(READY_TIMEOUT - 1);
   logic [7:0] wcnt_q, wcnt_d;
`else
   logic unused_cfg;
   assign unused_cfg = ^8'(READY_TIMEOUT);
`endif

   assign reqs = {ms_req, kb_req, in12_req};

   // search starts after the last granted requester
   always_comb begin
      win = 3'b000;
      unique case (1'b1)
         last_q[1]: win = reqs[2] ? 3'b100 : reqs[0] ? 3'b001 :
                          reqs[1] ? 3'b010 : 3'b000;
         last_q[2]: win = reqs[0] ? 3'b001 : reqs[1] ? 3'b010 :
                          reqs[2] ? 3'b100 : 3'b000;
         default:   win = reqs[1] ? 3'b010 : reqs[2] ? 3'b100 :
                          reqs[0] ? 3'b001 : 3'b000;
      endcase
   end

   always_ff @(posedge Clock_1us or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= S_IDLE;
         phase_q <= 1'b0;
         sel_q   <= 3'b000;
         last_q  <= 3'b001;
         cnt_q   <= 8'd0;
         pay0_q  <= 8'd0;
         pay1_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         pay0_q  <= pay0_d;
         pay1_q  <= pay1_d;
      end
   end

`ifdef IO_BUS_TIMEOUT_EN
   always_ff @(posedge Clock_1us or negedge Rst_n) begin
      if (!Rst_n) wcnt_q <= 8'd0;
      else        wcnt_q <= wcnt_d;
   end
`endif

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      sel_d   = sel_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      pay0_d  = pay0_q;
      pay1_d  = pay1_q;
      abort   = 1'b0;
`ifdef IO_BUS_TIMEOUT_EN
      wcnt_d  = wcnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (win != 3'b000) begin
               sel_d   = win;
               last_d  = win;
               phase_d = 1'b0;
               cnt_d   = 8'd0;
`ifdef IO_BUS_TIMEOUT_EN
               wcnt_d  = 8'd0;
`endif
               unique case (1'b1)
                  win[0]: begin
                     pay0_d = in12_cathode;
                     pay1_d = {4'b0, in12_anode};
                  end
                  win[1]: begin
                     pay0_d = kb_col;
                     pay1_d = 8'h09;
                  end
                  default: begin
                     pay0_d = ms_addr;
                     pay1_d = ms_data;
                  end
               endcase
               state_d = win[2] ? S_WAIT_RDY : S_SETUP;
            end
         end
         S_WAIT_RDY: begin
            if (ms6205_ready) begin
               state_d = S_SETUP;
               cnt_d   = 8'd0;
            end
`ifdef IO_BUS_TIMEOUT_EN
            else if (wcnt_q == TO_LAST) begin
               abort   = 1'b1;
               state_d = S_IDLE;
            end else begin
               wcnt_d = wcnt_q + 8'd1;
            end
`endif
         end
         S_SETUP: begin
            if (cnt_q == SETUP_LAST) begin
               state_d = S_STROBE;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_STROBE: begin
            if (cnt_q == STROBE_LAST) begin
               state_d = S_HOLD;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_HOLD: begin
            if (!phase_q) begin
               phase_d = 1'b1;
               state_d = sel_q[2] ? S_WAIT_RDY : S_SETUP;
`ifdef IO_BUS_TIMEOUT_EN
               wcnt_d  = 8'd0;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // outputs are decoded from the next state so the registers line up
   // with the state they belong to
   always_comb begin
      drive   = (state_d == S_SETUP) || (state_d == S_STROBE) ||
                (state_d == S_HOLD);
      stb     = (state_d == S_STROBE);
      bus_d   = drive ? (phase_d ? pay1_d : pay0_d) : 8'h00;
      wc_d    = stb & sel_d[0] & ~phase_d;
      wa_d    = stb & sel_d[0] &  phase_d;
      kw_d    = stb & sel_d[1] & ~phase_d;
      kr_d    = stb & sel_d[1] &  phase_d;
      ma_d    = stb & sel_d[2] & ~phase_d;
      md_d    = stb & sel_d[2] &  phase_d;
      last_ph = (state_d == S_HOLD) & phase_d;
      row_d   = kb_row;
      if ((state_q == S_STROBE) && (cnt_q == STROBE_LAST) &&
          phase_q && sel_q[1])
         row_d = keyboard_data_in;
   end

   always_ff @(posedge Clock_1us or negedge Rst_n) begin
      if (!Rst_n) begin
         emulData            <= 8'h00;
         in12_write_cathode  <= 1'b0;
         in12_write_anode    <= 1'b0;
         keyboard_write      <= 1'b0;
         keyboard_read       <= 1'b0;
         ms6205_write_addr_n <= 1'b1;
         ms6205_write_data_n <= 1'b1;
         in12_done           <= 1'b0;
         kb_done             <= 1'b0;
         ms_done             <= 1'b0;
         kb_row              <= 7'd0;
         busy                <= 1'b0;
      end else begin
         emulData            <= bus_d;
         in12_write_cathode  <= wc_d;
         in12_write_anode    <= wa_d;
         keyboard_write      <= kw_d;
         keyboard_read       <= kr_d;
         ms6205_write_addr_n <= ~ma_d;
         ms6205_write_data_n <= ~md_d;
         in12_done           <= last_ph & sel_d[0];
         kb_done             <= last_ph & sel_d[1];
         ms_done             <= (last_ph & sel_d[2]) | abort;
         kb_row              <= row_d;
         busy                <= (state_d != S_IDLE);
      end
   end

`ifdef IO_BUS_TIMEOUT_EN
   always_ff @(posedge Clock_1us or negedge Rst_n) begin
      if (!Rst_n) ms_timeout <= 1'b0;
      else        ms_timeout <= abort;
   end
`else
   assign ms_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_io_bus_scheduler.sv
// Directed bench for io_bus_scheduler: vector table plus
// hand sequences for arbitration, ready wait, reset and timeout.
module tb_io_bus_scheduler;

   logic       Clock_1us = 1'b0;
   logic       Rst_n = 1'b0;
   logic       in12_req = 1'b0;
   logic [7:0] in12_cathode = 8'h00;
   logic [3:0] in12_anode = 4'h0;
   logic       in12_done;
   logic       kb_req = 1'b0;
   logic [7:0] kb_col = 8'h00;
   logic [6:0] keyboard_data_in = 7'h00;
   logic [6:0] kb_row;
   logic       kb_done;
   logic       ms_req = 1'b0;
   logic [7:0] ms_addr = 8'h00;
   logic [7:0] ms_data = 8'h00;
   logic       ms6205_ready = 1'b0;
   logic       ms_done;
   logic       ms_timeout;
   logic [7:0] emulData;
   logic       in12_write_cathode;
   logic       in12_write_anode;
   logic       keyboard_write;
   logic       keyboard_read;
   logic       ms6205_write_addr_n;
   logic       ms6205_write_data_n;
   logic       busy;

   int n_chk = 0;
   int n_fail = 0;

   io_bus_scheduler dut (
      .Clock_1us           (Clock_1us),
      .Rst_n               (Rst_n),
      .in12_req            (in12_req),
      .in12_cathode        (in12_cathode),
      .in12_anode          (in12_anode),
      .in12_done           (in12_done),
      .kb_req              (kb_req),
      .kb_col              (kb_col),
      .keyboard_data_in    (keyboard_data_in),
      .kb_row              (kb_row),
      .kb_done             (kb_done),
      .ms_req              (ms_req),
      .ms_addr             (ms_addr),
      .ms_data             (ms_data),
      .ms6205_ready        (ms6205_ready),
      .ms_done             (ms_done),
      .ms_timeout          (ms_timeout),
      .emulData            (emulData),
      .in12_write_cathode  (in12_write_cathode),
      .in12_write_anode    (in12_write_anode),
      .keyboard_write      (keyboard_write),
      .keyboard_read       (keyboard_read),
      .ms6205_write_addr_n (ms6205_write_addr_n),
      .ms6205_write_data_n (ms6205_write_data_n),
      .busy                (busy)
   );

   always #5 Clock_1us = ~Clock_1us;

   // {in12 cath, in12 anode, kb write, kb read, ms addr, ms data}
   logic [5:0] stb;
   assign stb = {in12_write_cathode, in12_write_anode,
                 keyboard_write, keyboard_read,
                 ~ms6205_write_addr_n, ~ms6205_write_data_n};
   logic [2:0] dn;
   assign dn = {ms_done, kb_done, in12_done};

   typedef struct {
      logic       i_req;
      logic       k_req;
      logic [7:0] e_bus;
      logic [5:0] e_stb;
      logic [2:0] e_done;
      logic       e_busy;
      logic [6:0] e_row;
   } vec_t;

   vec_t tbl[30];

   function automatic vec_t mk(input logic i, input logic k,
                               input logic [7:0] b, input logic [5:0] s,
                               input logic [2:0] d, input logic y,
                               input logic [6:0] r);
      vec_t v;
      v.i_req = i; v.k_req = k; v.e_bus = b; v.e_stb = s;
      v.e_done = d; v.e_busy = y; v.e_row = r;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock_1us);
      #1;
   endtask

   task automatic do_reset();
      Rst_n = 1'b0;
      in12_req = 1'b0; kb_req = 1'b0; ms_req = 1'b0;
      repeat (2) tick();
      @(negedge Clock_1us);
      Rst_n = 1'b1;
      tick();
   endtask

   task automatic wait_done(output logic [2:0] d);
      d = 3'b000;
      for (int i = 0; i < 100 && d == 3'b000; i++) begin
         tick();
         d = dn;
      end
   endtask

   initial begin
      logic [2:0] d;
      logic [2:0] ord[3];
      int bad;
      int n;

      tbl[0]  = mk(1, 0, 8'hA5, 6'b000000, 3'b000, 1, 7'h00);
      tbl[1]  = mk(1, 0, 8'hA5, 6'b000000, 3'b000, 1, 7'h00);
      tbl[2]  = mk(1, 0, 8'hA5, 6'b100000, 3'b000, 1, 7'h00);
      tbl[3]  = mk(1, 0, 8'hA5, 6'b100000, 3'b000, 1, 7'h00);
      tbl[4]  = mk(1, 0, 8'hA5, 6'b100000, 3'b000, 1, 7'h00);
      tbl[5]  = mk(1, 0, 8'hA5, 6'b100000, 3'b000, 1, 7'h00);
      tbl[6]  = mk(1, 0, 8'hA5, 6'b000000, 3'b000, 1, 7'h00);
      tbl[7]  = mk(1, 0, 8'h03, 6'b000000, 3'b000, 1, 7'h00);
      tbl[8]  = mk(1, 0, 8'h03, 6'b000000, 3'b000, 1, 7'h00);
      tbl[9]  = mk(1, 0, 8'h03, 6'b010000, 3'b000, 1, 7'h00);
      tbl[10] = mk(1, 0, 8'h03, 6'b010000, 3'b000, 1, 7'h00);
      tbl[11] = mk(1, 0, 8'h03, 6'b010000, 3'b000, 1, 7'h00);
      tbl[12] = mk(1, 0, 8'h03, 6'b010000, 3'b000, 1, 7'h00);
      tbl[13] = mk(1, 0, 8'h03, 6'b000000, 3'b001, 1, 7'h00);
      tbl[14] = mk(0, 0, 8'h00, 6'b000000, 3'b000, 0, 7'h00);
      tbl[15] = mk(0, 1, 8'h04, 6'b000000, 3'b000, 1, 7'h00);
      tbl[16] = mk(0, 1, 8'h04, 6'b000000, 3'b000, 1, 7'h00);
      tbl[17] = mk(0, 1, 8'h04, 6'b001000, 3'b000, 1, 7'h00);
      tbl[18] = mk(0, 1, 8'h04, 6'b001000, 3'b000, 1, 7'h00);
      tbl[19] = mk(0, 1, 8'h04, 6'b001000, 3'b000, 1, 7'h00);
      tbl[20] = mk(0, 1, 8'h04, 6'b001000, 3'b000, 1, 7'h00);
      tbl[21] = mk(0, 1, 8'h04, 6'b000000, 3'b000, 1, 7'h00);
      tbl[22] = mk(0, 1, 8'h09, 6'b000000, 3'b000, 1, 7'h00);
      tbl[23] = mk(0, 1, 8'h09, 6'b000000, 3'b000, 1, 7'h00);
      tbl[24] = mk(0, 1, 8'h09, 6'b000100, 3'b000, 1, 7'h00);
      tbl[25] = mk(0, 1, 8'h09, 6'b000100, 3'b000, 1, 7'h00);
      tbl[26] = mk(0, 1, 8'h09, 6'b000100, 3'b000, 1, 7'h00);
      tbl[27] = mk(0, 1, 8'h09, 6'b000100, 3'b000, 1, 7'h00);
      tbl[28] = mk(0, 1, 8'h09, 6'b000000, 3'b010, 1, 7'h12);
      tbl[29] = mk(0, 0, 8'h00, 6'b000000, 3'b000, 0, 7'h12);

      in12_cathode = 8'hA5;
      in12_anode = 4'h3;
      kb_col = 8'h04;
      keyboard_data_in = 7'h12;

      // reset values while Rst_n is held low
      repeat (2) tick();
      chk("rst_bus", emulData, 8'h00);
      chk("rst_stb", stb, 6'b000000);
      chk("rst_done", dn, 3'b000);
      chk("rst_busy", busy, 1'b0);
      chk("rst_row", kb_row, 7'h00);
      chk("rst_tmo", ms_timeout, 1'b0);
      do_reset();

      for (int v = 0; v < 30; v++) begin
         in12_req = tbl[v].i_req;
         kb_req = tbl[v].k_req;
         tick();
         chk($sformatf("tbl%0d_bus", v), emulData, tbl[v].e_bus);
         chk($sformatf("tbl%0d_stb", v), stb, tbl[v].e_stb);
         chk($sformatf("tbl%0d_done", v), dn, tbl[v].e_done);
         chk($sformatf("tbl%0d_busy", v), busy, tbl[v].e_busy);
         chk($sformatf("tbl%0d_row", v), kb_row, tbl[v].e_row);
      end

      // round-robin from reset: kb, ms, in12, then kb again
      do_reset();
      ms6205_ready = 1'b1;
      ms_addr = 8'h10;
      ms_data = 8'h20;
      ord[0] = 3'b010; ord[1] = 3'b100; ord[2] = 3'b001;
      in12_req = 1'b1; kb_req = 1'b1; ms_req = 1'b1;
      for (int t = 0; t < 3; t++) begin
         wait_done(d);
         chk($sformatf("rr%0d_grant", t), d, ord[t]);
         if (d[0]) in12_req = 1'b0;
         if (d[1]) kb_req = 1'b0;
         if (d[2]) ms_req = 1'b0;
         tick();
         chk($sformatf("rr%0d_gap_bus", t), emulData, 8'h00);
         chk($sformatf("rr%0d_gap_busy", t), busy, 1'b0);
      end
      in12_req = 1'b1; kb_req = 1'b1;
      tick();
      chk("rr_again_bus", emulData, kb_col);
      wait_done(d);
      chk("rr_again_grant", d, 3'b010);
      in12_req = 1'b0; kb_req = 1'b0;
      tick();
      chk("rr_again_idle", busy, 1'b0);

      // ms write held off by ms6205_ready
      ms6205_ready = 1'b0;
      ms_addr = 8'h1F;
      ms_data = 8'h41;
      ms_req = 1'b1;
      tick();
      chk("ms_wait_busy", busy, 1'b1);
      chk("ms_wait_bus", emulData, 8'h00);
      ms_addr = 8'hEE;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (stb != 6'b0 || emulData != 8'h00 || !busy) bad++;
      end
      chk("ms_wait_quiet", bad, 0);
      ms6205_ready = 1'b1;
      for (int k = 0; k < 15; k++) begin
         logic [7:0] eb;
         logic [5:0] es;
         eb = (k < 7) ? 8'h1F : (k == 7) ? 8'h00 : 8'h41;
         es = (k >= 2 && k <= 5) ? 6'b000010 :
              (k >= 10 && k <= 13) ? 6'b000001 : 6'b000000;
         tick();
         chk($sformatf("ms%0d", k), {emulData, stb, dn},
             {eb, es, (k == 14) ? 3'b100 : 3'b000});
         if (k == 14) ms_req = 1'b0;
      end
      tick();
      chk("ms_end_idle", {busy, emulData}, 9'h000);
      chk("ms_no_tmo", ms_timeout, 1'b0);

      // asynchronous reset in the middle of a cathode strobe
      kb_col = 8'h5A;
      in12_req = 1'b1;
      repeat (3) tick();
      chk("rs_pre_stb", in12_write_cathode, 1'b1);
      kb_req = 1'b1;
      #2;
      Rst_n = 1'b0;
      #1;
      chk("rs_stb", stb, 6'b000000);
      chk("rs_bus", emulData, 8'h00);
      chk("rs_busy", busy, 1'b0);
      chk("rs_row", kb_row, 7'h00);
      tick();
      @(negedge Clock_1us);
      Rst_n = 1'b1;
      tick();
      chk("rs_kb_first", emulData, 8'h5A);
      wait_done(d);
      chk("rs_kb_done", d, 3'b010);
      kb_req = 1'b0;
      wait_done(d);
      chk("rs_in12_next", d, 3'b001);
      in12_req = 1'b0;
      tick();

`ifdef IO_BUS_TIMEOUT_EN
      // ready stuck low: abort after 255 WAIT_RDY cycles
      do_reset();
      ms6205_ready = 1'b0;
      in12_cathode = 8'hC3;
      ms_req = 1'b1;
      in12_req = 1'b1;
      bad = 0;
      n = 0;
      for (int i = 0; i < 400 && !ms_timeout; i++) begin
         tick();
         n++;
         if (stb[1:0] != 2'b00) bad++;
      end
      chk("to_cycles", n, 256);
      chk("to_done", ms_done, 1'b1);
      chk("to_no_stb", bad, 0);
      ms_req = 1'b0;
      tick();
      chk("to_in12_bus", emulData, 8'hC3);
      chk("to_pulse_end", {ms_timeout, ms_done}, 2'b00);
      wait_done(d);
      chk("to_in12_done", d, 3'b001);
      in12_req = 1'b0;
      tick();
`else
      n = 0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/io_bus_scheduler.md
# io_bus_scheduler

Time-multiplexes the shared 8-bit emulator output bus (`emulData`) and its peripheral strobes between three requesters: the IN-12 display scanner, the keyboard matrix scanner and the MS6205 character display writer. Each requester issues a two-phase transaction. The scheduler grants requesters round-robin, drives the bus and the strobe for each phase with fixed setup and strobe widths, and waits on `ms6205_ready` for display writes. It sits between the emulator's scan/refresh logic and the front-panel pins, replacing ad-hoc per-state output muxing.

## Interface
Parameters:
- `SETTLE_US`, default 2: cycles the data is driven before the strobe (≥1).
- `STROBE_US`, default 4: strobe width in cycles (≥1).
- `READY_TIMEOUT`, default 255: maximum `ms6205_ready` wait in cycles (8-bit counter).

Ports:
- `Clock_1us` in 1: the only clock.
- `Rst_n` in 1: reset, asynchronous, active-low.
- `in12_req` in 1; `in12_cathode` in 8; `in12_anode` in 4; `in12_done` out 1.
- `kb_req` in 1; `kb_col` in 8; `keyboard_data_in` in 7 (row pins); `kb_row` out 7; `kb_done` out 1.
- `ms_req` in 1; `ms_addr` in 8; `ms_data` in 8; `ms6205_ready` in 1; `ms_done` out 1; `ms_timeout` out 1.
- `emulData` out 8: shared bus.
- `in12_write_cathode`, `in12_write_anode`, `keyboard_write`, `keyboard_read` out 1 each: active-high strobes.
- `ms6205_write_addr_n`, `ms6205_write_data_n` out 1 each: active-low strobes.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- **States:** IDLE, WAIT_RDY, SETUP, STROBE, HOLD. A phase bit selects phase 0 or phase 1.
- **Transactions:**
  - in12: phase 0 drives `in12_cathode` with `in12_write_cathode`; phase 1 drives `{4'b0, in12_anode}` with `in12_write_anode`.
  - kb: phase 0 drives `kb_col` with `keyboard_write`; phase 1 drives `8'h09` with `keyboard_read`. `keyboard_data_in` is sampled into `kb_row` on the last STROBE cycle of phase 1.
  - ms: phase 0 drives `ms_addr` with `ms6205_write_addr_n`; phase 1 drives `ms_data` with `ms6205_write_data_n`.
- **Arbitration (IDLE):**
  - Search order is round-robin, starting after the last granted requester, in the sequence in12 → kb → ms. The pointer resets to in12, so kb has first priority after reset.
  - The winner's payload is latched at grant, so later payload changes are ignored.
  - The next state is SETUP, or WAIT_RDY for ms.
- **WAIT_RDY:** entered before each ms phase. The FSM moves to SETUP on the cycle after `ms6205_ready` is seen high.
- **SETUP:** bus driven, strobe inactive, for `SETTLE_US` cycles.
- **STROBE:** bus driven, strobe active, for `STROBE_US` cycles.
- **HOLD:** 1 cycle, bus still driven, strobe inactive. After phase 0 the FSM goes to phase 1 (SETUP, or WAIT_RDY for ms). After phase 1 it returns to IDLE.
- **Done pulse:** `*_done` is high for exactly the HOLD cycle of phase 1. The requester must drop `req` by the following edge; a `req` still high in IDLE is treated as a new request.
- **Req dropped mid-transaction:** ignored; the transaction completes.
- **Bus contents:** `emulData` is `8'h00` in IDLE and WAIT_RDY. Strobes are never asserted outside STROBE, and only one strobe is asserted at a time.
- **Reset (asynchronous, including mid-transaction):**
  - State IDLE, pointer in12, `emulData` = 0.
  - All active-high strobes 0; `ms6205_write_*_n` = 1.
  - `kb_row` = 0; all done outputs, `ms_timeout` and `busy` = 0.

## Timing
- All outputs are registered, including strobes and the bus.
- **Grant latency:** `req` high in IDLE at edge N puts the FSM in SETUP (or WAIT_RDY) from edge N+1.
- **Phase length:** `SETTLE_US + STROBE_US + 1` cycles, which is 7 with defaults.
- **in12/kb transaction:** 14 cycles from grant to the end of the done cycle. IDLE then lasts at least 1 cycle between transactions.
- **ms transaction:** 14 cycles plus each WAIT_RDY span. The minimum WAIT_RDY span is 1 cycle.
- **Data timing:** data is stable `SETTLE_US` cycles before the strobe asserts and 1 cycle after it deasserts.
- **`kb_row`:** updates on the edge that ends the last phase-1 STROBE cycle and holds until the next kb transaction.

## Configuration
- **`IO_BUS_TIMEOUT_EN` defined:** WAIT_RDY counts cycles. If `READY_TIMEOUT` cycles elapse with `ms6205_ready` low:
  - the transaction is aborted and no further strobe is issued;
  - `ms_timeout` and `ms_done` pulse together for 1 cycle;
  - the FSM returns to IDLE and the pointer advances past ms.
- **`IO_BUS_TIMEOUT_EN` not defined:** WAIT_RDY waits indefinitely, and `ms_timeout` is tied to 0.

## Test plan
All scenarios use default parameters.
- **in12 single transaction:** `in12_req` with cathode `8'hA5`, anode `4'h3` → `emulData` = `A5` for 7 cycles, with `in12_write_cathode` high on cycles 3–6 of the transaction. Then `emulData` = `03` with `in12_write_anode` high on cycles 10–13. `in12_done` is high on cycle 14.
- **kb read:** `kb_col` = `8'h04`, `keyboard_data_in` = `7'h12` held → `keyboard_write` then `keyboard_read` pulses of 4 cycles each. `emulData` = `09` during phase 1. `kb_row` = `7'h12` after the strobe, and `kb_done` pulses once.
- **Round-robin:** all three `req` raised together and each dropped on its done → grant order kb, ms, in12, then kb again on re-request. The bus stays `00` in the 1-cycle IDLE gaps.
- **ms ready wait:** `ms_req` with addr `8'h1F`, data `8'h41`; `ms6205_ready` low for 20 cycles, then high → no strobe before ready. `ms6205_write_addr_n` is low for 4 cycles after 2 setup cycles, followed by `ms6205_write_data_n` low, and `ms_done` pulses once.
- **Timeout (`IO_BUS_TIMEOUT_EN` defined):** `ms6205_ready` stuck low → `ms_timeout` and `ms_done` pulse after 255 WAIT_RDY cycles, no active-low strobe ever, and a pending `in12_req` is then granted.
- **Reset mid-STROBE:** `Rst_n` pulled low during an `in12_write_cathode` pulse → the strobe drops immediately and all outputs take their reset values. After release with `kb_req` high, kb is granted first.
